// File: rtl/ring_pkg.sv
// Types and constants shared by the ring buffer's random-read arbiters.
package ring_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    // Geometry of the 128-entry ring buffer this arbiter fronts.
    localparam int RING_ADDR_W = 7;
    localparam int RING_DATA_W = 4;

    localparam logic [7:0] TMO_SAT = 8'hFF;

endpackage

// File: rtl/ring_rand_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] gnt,
    output logic          any
);

    always_comb begin
        gnt = '0;
        any = 1'b0;
        // Walk from farthest to nearest so the closest set bit is the last to win.
        for (int k = N - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                gnt = IW'(idx);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ring_rand_arbiter.sv
// Round-robin arbiter sharing the ring buffer's random-read port, with a busy-ring watchdog.
module ring_rand_arbiter
    import ring_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = RING_ADDR_W,
    parameter int DATA_W = RING_DATA_W,
    parameter int TMO_W  = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    rsp_err,
    output logic                    busy,
    output logic [ADDR_W-1:0]       ring_rand_rd_addr,
    output logic                    ring_rand_rd_en,
    input  logic                    ring_rand_rd_valid,
    input  logic [DATA_W-1:0]       ring_dout,
    output logic [7:0]              tmo_count
);

    localparam int IW = $clog2(N_REQ);
    // Fires on the edge that ends the (2**TMO_W-1)th ISSUE cycle.
    localparam logic [TMO_W-1:0] WD_LIM = {{(TMO_W-1){1'b1}}, 1'b0};

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   gnt;
    logic [TMO_W-1:0] wd;
    logic            armed;
    logic [IW-1:0]   pick_gnt;
    logic            pick_any;
    logic [IW-1:0]   ptr_next;

    rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
        .req (req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .any (pick_any)
    );

    assign ptr_next = (pick_gnt == IW'(N_REQ - 1)) ? '0 : pick_gnt + IW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            ptr               <= '0;
            gnt               <= '0;
            wd                <= '0;
            armed             <= 1'b0;
            rsp_valid         <= '0;
            rsp_data          <= '0;
            rsp_err           <= 1'b0;
            busy              <= 1'b0;
            ring_rand_rd_addr <= '0;
            ring_rand_rd_en   <= 1'b0;
            tmo_count         <= '0;
        end else begin
            armed     <= 1'b1;
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    // Skip the cycle the response pulse is visible so its owner can drop req.
                    if (armed && rsp_valid == '0 && pick_any) begin
                        gnt               <= pick_gnt;
                        ptr               <= ptr_next;
                        ring_rand_rd_addr <= req_addr[int'(pick_gnt)*ADDR_W +: ADDR_W];
                        ring_rand_rd_en   <= 1'b1;
                        wd                <= '0;
                        busy              <= 1'b1;
                        state             <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (ring_rand_rd_valid) begin
                        rsp_data        <= ring_dout;
                        rsp_err         <= 1'b0;
                        ring_rand_rd_en <= 1'b0;
                        state           <= RESP;
                    end else if (wd == WD_LIM) begin
                        rsp_data        <= '0;
                        rsp_err         <= 1'b1;
                        ring_rand_rd_en <= 1'b0;
                        if (tmo_count != TMO_SAT)
                            tmo_count <= tmo_count + 8'd1;
                        state           <= RESP;
                    end else begin
                        wd <= wd + TMO_W'(1);
                    end
                end
                RESP: begin
                    rsp_valid <= N_REQ'(1) << gnt;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ring_rand_arbiter.sv
// Scoreboard bench for ring_rand_arbiter against a 3-stage random-read ring model.
module tb_ring_rand_arbiter;

    localparam int N  = 4;
    localparam int AW = 7;
    localparam int DW = 4;
    localparam int TW = 6;

    typedef struct {
        int         idx;
        logic [3:0] data;
        logic       err;
        int         due;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            rsp_err;
    logic            busy;
    logic [AW-1:0]   ring_rand_rd_addr;
    logic            ring_rand_rd_en;
    logic            ring_valid = 1'b0;
    logic [DW-1:0]   ring_dout = '0;
    logic [7:0]      tmo_count;

    logic            p1 = 1'b0;
    logic            p2 = 1'b0;
    logic [AW-1:0]   acc_addr = '0;
    int              cyc = 0;
    int              busy_until = 0;
    int              accepts = 0;
    int              en_cycles = 0;

    int   tests = 0;
    int   fails = 0;
    exp_t q[$];

    ring_rand_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TMO_W(TW)) dut (
        .clk                (clk),
        .rst                (rst),
        .req                (req),
        .req_addr           (req_addr),
        .rsp_valid          (rsp_valid),
        .rsp_data           (rsp_data),
        .rsp_err            (rsp_err),
        .busy               (busy),
        .ring_rand_rd_addr  (ring_rand_rd_addr),
        .ring_rand_rd_en    (ring_rand_rd_en),
        .ring_rand_rd_valid (ring_valid),
        .ring_dout          (ring_dout),
        .tmo_count          (tmo_count)
    );

    always #5 clk = ~clk;

    // Ring model: accepts when not re-priming and no access in flight; data = ~addr[3:0].
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ring_rand_rd_en) en_cycles <= en_cycles + 1;
        p1 <= 1'b0;
        if (ring_rand_rd_en && !p1 && !p2 && !ring_valid && cyc >= busy_until) begin
            p1       <= 1'b1;
            acc_addr <= ring_rand_rd_addr;
            accepts  <= accepts + 1;
        end
        p2         <= p1;
        ring_valid <= p2;
        if (p2) ring_dout <= ~acc_addr[3:0];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic issue(input int i, input logic [AW-1:0] a);
        req_addr[i*AW +: AW] = a;
        req[i] = 1'b1;
    endtask

    task automatic expect_rsp(input int i, input logic [3:0] d, input logic e, input int due);
        exp_t x;
        x.idx = i; x.data = d; x.err = e; x.due = due;
        q.push_back(x);
    endtask

    // Requester side: drop req on its response, until every expected response is seen.
    task automatic drain(input string name, input int max);
        int n;
        n = 0;
        while ((q.size() != 0 || busy) && n < max) begin
            @(negedge clk); #1;
            req = req & ~rsp_valid;
            n++;
        end
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL %s_timeout pending=%0d expected=0", name, q.size());
        end
        @(negedge clk);
    endtask

    // Monitor: pops one expectation per response pulse.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && rsp_valid != '0) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL stray_rsp rsp_valid=%b expected=none", rsp_valid);
                end else begin
                    e = q.pop_front();
                    if (rsp_valid != (N'(1) << e.idx) || rsp_data != e.data ||
                        rsp_err != e.err || cyc != e.due) begin
                        fails++;
                        $display("FAIL rsp actual v=%b d=%h e=%b cyc=%0d expected v=%b d=%h e=%b cyc=%0d",
                                 rsp_valid, rsp_data, rsp_err, cyc,
                                 N'(1) << e.idx, e.data, e.err, e.due);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int t0, e0, a0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_en", ring_rand_rd_en, 0);
        check("rst_addr", ring_rand_rd_addr, 0);
        check("rst_busy_tmo", {busy, rsp_err, rsp_data, tmo_count}, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 1: single request
        t0 = cyc; e0 = en_cycles; a0 = accepts;
        issue(0, 7'd5);
        expect_rsp(0, 4'hA, 1'b0, t0 + 6);
        drain("t1", 40);
        check("t1_en_cycles", en_cycles - e0, 4);
        check("t1_accepts", accepts - a0, 1);

        // 2: all four, pointer reset to 0
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        t0 = cyc;
        issue(0, 7'd1); issue(1, 7'd2); issue(2, 7'd3); issue(3, 7'd4);
        expect_rsp(0, 4'hE, 1'b0, t0 + 6);
        expect_rsp(1, 4'hD, 1'b0, t0 + 13);
        expect_rsp(2, 4'hC, 1'b0, t0 + 20);
        expect_rsp(3, 4'hB, 1'b0, t0 + 27);
        drain("t2", 80);

        // 3: ring re-priming for 20 cycles
        t0 = cyc; e0 = en_cycles; a0 = accepts;
        busy_until = t0 + 21;
        issue(1, 7'd9);
        expect_rsp(1, 4'h6, 1'b0, t0 + 26);
        drain("t3", 80);
        check("t3_en_cycles", en_cycles - e0, 24);
        check("t3_accepts", accepts - a0, 1);

        // 4: ring never responds -> timeout, then a normal access
        t0 = cyc; e0 = en_cycles;
        busy_until = t0 + 100000;
        issue(0, 7'h10);
        expect_rsp(0, 4'h0, 1'b1, t0 + 65);
        drain("t4", 120);
        check("t4_en_cycles", en_cycles - e0, 63);
        check("t4_tmo_count", tmo_count, 1);
        busy_until = 0;
        t0 = cyc;
        issue(3, 7'h2C);
        expect_rsp(3, 4'h3, 1'b0, t0 + 6);
        drain("t4b", 40);
        check("t4b_tmo_count", tmo_count, 1);

        // 5: req[2] dropped mid-ISSUE, then 4'b1100 starts at requester 3
        t0 = cyc;
        issue(2, 7'h35);
        expect_rsp(2, 4'hA, 1'b0, t0 + 6);
        repeat (2) @(negedge clk);
        check("t5_en_mid", ring_rand_rd_en, 1);
        req[2] = 1'b0;
        drain("t5", 40);
        t0 = cyc;
        issue(3, 7'h41); issue(2, 7'h12);
        expect_rsp(3, 4'hE, 1'b0, t0 + 6);
        expect_rsp(2, 4'hD, 1'b0, t0 + 13);
        drain("t5b", 60);

        // 6: reset mid-ISSUE
        issue(1, 7'h0B);
        repeat (2) @(negedge clk);
        check("t6_en_before", ring_rand_rd_en, 1);
        rst = 1'b0;
        #1;
        check("t6_en_async", ring_rand_rd_en, 0);
        req = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        check("t6_rsp_valid", rsp_valid, 0);
        check("t6_outputs", {busy, ring_rand_rd_en, ring_rand_rd_addr, rsp_err, rsp_data}, 0);
        check("t6_tmo_count", tmo_count, 0);
        check("end_queue_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ring_rand_arbiter.md
Name: ring_rand_arbiter

Overview:
- Shares the single random-access read port of the 128-entry ring buffer between N_REQ requesters (e.g. a channel-selector readout and a monitor/debug reader).
- Round-robin grant. Holds one outstanding ring access at a time.
- Converts the ring's fixed 3-stage rand_rd_en/rand_rd_valid sequence into a per-requester request/response handshake.
- Adds a watchdog, so a ring that stays busy (continuous writes re-priming it) cannot hang a requester.

Parameters:
N_REQ, 4, number of requesters (2..8)
ADDR_W, 7, ring address width
DATA_W, 4, ring data width
TMO_W, 6, watchdog counter width; timeout fires after 2**TMO_W-1 cycles in ISSUE

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
req  in  N_REQ  per-requester read request; level, held until rsp_valid bit seen
req_addr  in  N_REQ*ADDR_W  packed addresses; slot i = bits [i*ADDR_W +: ADDR_W]; stable while req[i] high
rsp_valid  out  N_REQ  one-hot, 1-cycle pulse: response for requester i
rsp_data  out  DATA_W  response data, valid with rsp_valid
rsp_err  out  1  timeout flag, valid with rsp_valid (rsp_data=0 when set)
busy  out  1  high in ISSUE or RESP
ring_rand_rd_addr  out  ADDR_W  to ring rand_rd_addr
ring_rand_rd_en  out  1  to ring rand_rd_en
ring_rand_rd_valid  in  1  from ring rand_rd_valid
ring_dout  in  DATA_W  from ring dout; sampled only when ring_rand_rd_valid=1
tmo_count  out  8  saturating count of timeouts since reset

Behaviour:
- All outputs and flops are registered. They clear asynchronously when rst=0:
  - rsp_valid=0, rsp_data=0, rsp_err=0, busy=0
  - ring_rand_rd_en=0, ring_rand_rd_addr=0, tmo_count=0
  - state=IDLE, round-robin pointer=0
- Release of reset is used synchronously; no request is sampled in the first cycle after release.
- IDLE:
  - If any req bit is high, grant the first set bit at or after the pointer, wrapping modulo N_REQ.
  - Latch gnt index and req_addr[gnt] into ring_rand_rd_addr.
  - Set ring_rand_rd_en=1 and clear the watchdog. Next state is ISSUE.
  - Pointer becomes gnt+1 (mod N_REQ).
- ISSUE:
  - ring_rand_rd_en is held high and the address held stable.
  - The ring only accepts the access when it is not re-priming.
  - On ring_rand_rd_valid=1:
    - Capture ring_dout into rsp_data and clear ring_rand_rd_en on the same edge.
    - The ring ignores en in its final access cycle, so no second access is started.
    - rsp_err=0. Next state is RESP.
  - On watchdog reaching 2**TMO_W-1 without valid:
    - ring_rand_rd_en=0, rsp_data=0, rsp_err=1.
    - tmo_count increments, saturating at 255. Next state is RESP.
  - If valid and timeout coincide, valid wins.
- RESP:
  - rsp_valid[gnt]=1 for exactly one cycle. Next state is IDLE.
  - The requester must drop or renew req by the following cycle. The arbiter does not re-sample req until IDLE.
- Latency from req rising in IDLE with the ring idle to rsp_valid is 6 cycles:
  - edge1: grant/en
  - edge2: ring accepts
  - edge3–4: ring pipeline
  - edge5: capture
  - edge6: rsp_valid visible
- Throughput is one access per 7 cycles per port worst case.
- If req[gnt] drops during ISSUE, the access still completes and the response pulse is still issued; the requester ignores it.
- Simultaneous requests are served strictly round-robin. No requester waits more than N_REQ-1 grants.
- Address passes through unchanged; the arbiter does not range-check against the ring fill level.
- Reset asserted mid-ISSUE: en drops immediately and no response is issued. The ring's own reset is separate.

Decomposition:
- Package ring_pkg holds:
  - state enum (IDLE, ISSUE, RESP)
  - default ADDR_W/DATA_W constants shared with the ring buffer
  - timeout saturation constant
- Sub-module rr_pick (combinational round-robin first-set-from-pointer, N_REQ wide, outputs gnt index + any). Reused by future arbiters.

Test Plan:
1. Single request: req=4'b0001, addr0=7'd5, ring models 3-cycle valid with dout=4'hA → rsp_valid=4'b0001 at cycle 6 with rsp_data=4'hA, rsp_err=0; ring_rand_rd_en high exactly 4 cycles.
2. All four requesting, addrs 1/2/3/4, pointer=0 → grants 0,1,2,3 in order; rsp_data matches each addr's model data; 7 cycles per access.
3. Ring busy 20 cycles (ignores en), then serves → rsp_valid 20 cycles late, correct data, single ring access (rand_rd_en never re-triggers after valid).
4. Ring never responds, TMO_W=6 → rsp_err=1 and rsp_data=0 after 63 ISSUE cycles; tmo_count=1; next request served normally.
5. req[2] drops during ISSUE → rsp_valid[2] still pulses once; pointer=3; next grant goes to requester 3 when req=4'b1100.
6. rst low mid-ISSUE → ring_rand_rd_en=0 asynchronously; after release with req=0, all outputs 0 and state IDLE; no stray rsp_valid.
